// File: rtl/dsp48a1_mac_seq_if.sv
// Operand stream and result stream between a sample source and dsp48a1_mac_seq.
interface dsp48a1_mac_seq_if #(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned WIDTH_2 = 48
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_last;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH_2-1:0] res_data;
  logic               res_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready,
    input  in_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready,
    output in_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/dsp48a1_mac_seq.sv
// Operand-side sequencer for one DSP48A1 slice (A1REG/B1REG/MREG/PREG/OPMODEREG = 1).
// Streams (a, b) pairs into the slice with OPMODE aligned one cycle behind the
// operands, then captures the 48-bit dot product from P four cycles after the last beat.
// Optional feature: define DSP48A1_MAC_SEQ_CARRY_EN to track a sticky carry-out in res_ovf.
module dsp48a1_mac_seq #(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned WIDTH_2 = 48
) (
  input  logic               clk,
  input  logic               rst,
  dsp48a1_mac_seq_if.slave   s_if,
  output logic [WIDTH-1:0]   o_dsp_a,
  output logic [WIDTH-1:0]   o_dsp_b,
  output logic [7:0]         o_dsp_opmode,
  input  logic [WIDTH_2-1:0] i_dsp_p,
  input  logic               i_dsp_carryout
);

  localparam int unsigned CNT_W     = 3;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(3);
  localparam logic [7:0] OP_FIRST  = 8'h01;  // P = M
  localparam logic [7:0] OP_ACCUM  = 8'h09;  // P = P + M
  localparam logic [7:0] OP_BUBBLE = 8'h08;  // P = P + 0

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;
  logic               w_first;
  logic               w_capture;
  logic               w_in_ready_nxt;
  logic               w_res_valid_nxt;
  logic               w_res_ovf;
  logic               r_in_ready;
  logic               r_res_valid;
  logic               r_beat_vld;
  logic               r_beat_first;
  logic [WIDTH_2-1:0] r_res_data;
  logic [WIDTH-1:0]   r_dsp_a;
  logic [WIDTH-1:0]   r_dsp_b;
  logic [7:0]         r_dsp_opmode;

  assign w_accept = s_if.in_valid && r_in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = s_if.in_last ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (w_accept && s_if.in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cnt == '0) w_state_nxt = S_HOLD;
      S_HOLD:  if (s_if.res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode: first-beat tag, drain counter, capture strobe, handshakes.
  always_comb begin
    w_first         = 1'b0;
    w_capture       = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_in_ready_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACCUM);
    w_res_valid_nxt = (w_state_nxt == S_HOLD);
    case (r_state)
      S_IDLE: begin
        w_first = w_accept;
        if (w_accept && s_if.in_last) w_cnt_nxt = DRAIN_LOAD;
      end
      S_ACCUM: begin
        if (w_accept && s_if.in_last) w_cnt_nxt = DRAIN_LOAD;
      end
      S_DRAIN: begin
        if (r_cnt == '0) w_capture = 1'b1;
        else             w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Registered handshake outputs and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Operand launch; OPMODE follows one cycle later to meet the slice's extra A/B-to-M stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dsp_a      <= '0;
      r_dsp_b      <= '0;
      r_beat_vld   <= 1'b0;
      r_beat_first <= 1'b0;
      r_dsp_opmode <= 8'h00;
    end else begin
      r_dsp_a      <= w_accept ? s_if.in_a : '0;
      r_dsp_b      <= w_accept ? s_if.in_b : '0;
      r_beat_vld   <= w_accept;
      r_beat_first <= w_first;
      if (r_beat_vld) r_dsp_opmode <= r_beat_first ? OP_FIRST : OP_ACCUM;
      else            r_dsp_opmode <= OP_BUBBLE;
    end
  end

  // Result capture from slice P once the last beat has propagated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_res_data <= '0;
    else if (w_capture) r_res_data <= i_dsp_p;
  end

`ifdef DSP48A1_MAC_SEQ_CARRY_EN
  logic [3:0] r_tag;
  logic       r_res_ovf;

  // Beat tags delayed to the cycle its CARRYOUT is visible; OR carries into a sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag     <= '0;
      r_res_ovf <= 1'b0;
    end else begin
      r_tag <= {r_tag[2:0], w_accept};
      if (w_first)                          r_res_ovf <= 1'b0;
      else if (r_tag[3] && i_dsp_carryout)  r_res_ovf <= 1'b1;
    end
  end

  assign w_res_ovf = r_res_ovf;
`else
  logic w_unused_carry;
  assign w_unused_carry = i_dsp_carryout;
  assign w_res_ovf      = 1'b0;
`endif

  assign s_if.in_ready  = r_in_ready;
  assign s_if.res_valid = r_res_valid;
  assign s_if.res_data  = r_res_data;
  assign s_if.res_ovf   = w_res_ovf;
  assign o_dsp_a        = r_dsp_a;
  assign o_dsp_b        = r_dsp_b;
  assign o_dsp_opmode   = r_dsp_opmode;

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Bench for dsp48a1_mac_seq with a behavioural DSP48A1 slice and a dot-product reference.
module tb_dsp48a1_mac_seq;
  localparam int unsigned WIDTH   = 18;
  localparam int unsigned WIDTH_2 = 48;
  localparam logic [17:0] MAXV    = 18'h3FFFF;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   dsp_a;
  logic [WIDTH-1:0]   dsp_b;
  logic [7:0]         dsp_opmode;
  logic [WIDTH_2-1:0] dsp_p;
  logic               dsp_cy;

  dsp48a1_mac_seq_if #(.WIDTH(WIDTH), .WIDTH_2(WIDTH_2)) u_if ();

  dsp48a1_mac_seq #(.WIDTH(WIDTH), .WIDTH_2(WIDTH_2)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .s_if           (u_if),
    .o_dsp_a        (dsp_a),
    .o_dsp_b        (dsp_b),
    .o_dsp_opmode   (dsp_opmode),
    .i_dsp_p        (dsp_p),
    .i_dsp_carryout (dsp_cy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: A1/B1 -> M -> P, OPMODE registered once, CARRYOUT registered with P.
  logic [17:0] s_a1, s_b1;
  logic [35:0] s_m;
  logic [7:0]  s_op;
  logic [48:0] s_sum;
  always_comb
    s_sum = 49'((s_op[3:2] == 2'b10) ? dsp_p : 48'd0) +
            49'((s_op[1:0] == 2'b01) ? {12'd0, s_m} : 48'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_op <= '0; dsp_p <= '0; dsp_cy <= 1'b0;
    end else begin
      s_a1   <= dsp_a;
      s_b1   <= dsp_b;
      s_m    <= s_a1 * s_b1;
      s_op   <= dsp_opmode;
      dsp_p  <= s_sum[47:0];
      dsp_cy <= s_sum[48];
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic        busy, res_vis, in_dot, exp_ovf;
  int          cnt;
  logic [7:0]  prev_code;
  logic [63:0] sum;
  logic [47:0] exp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, update the reference, compare all outputs.
  task automatic step(input logic v, input logic [17:0] a, input logic [17:0] b,
                      input logic last, input logic rr);
    logic       acc, hs;
    logic [7:0] code;
    u_if.in_valid  = v;
    u_if.in_a      = a;
    u_if.in_b      = b;
    u_if.in_last   = last;
    u_if.res_ready = rr;
    acc = v && !busy;
    hs  = res_vis && rr;
    @(posedge clk); #1;
    if (hs) begin res_vis = 1'b0; busy = 1'b0; end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) res_vis = 1'b1;
    end
    code = 8'h08;
    if (acc) begin
      code = in_dot ? 8'h09 : 8'h01;
      if (!in_dot) sum = '0;
      sum    = sum + 64'(a) * 64'(b);
      in_dot = 1'b1;
      if (last) begin
        in_dot   = 1'b0;
        busy     = 1'b1;
        cnt      = 4;
        exp_data = sum[47:0];
`ifdef DSP48A1_MAC_SEQ_CARRY_EN
        exp_ovf  = (sum[63:48] != 16'd0);
`else
        exp_ovf  = 1'b0;
`endif
      end
    end
    chk("in_ready", 64'(u_if.in_ready), 64'(!busy));
    chk("res_valid", 64'(u_if.res_valid), 64'(res_vis));
    if (res_vis) begin
      chk("res_data", 64'(u_if.res_data), 64'(exp_data));
      chk("res_ovf", 64'(u_if.res_ovf), 64'(exp_ovf));
    end
    chk("dsp_a", 64'(dsp_a), acc ? 64'(a) : 64'd0);
    chk("dsp_b", 64'(dsp_b), acc ? 64'(b) : 64'd0);
    chk("dsp_opmode", 64'(dsp_opmode), 64'(prev_code));
    prev_code = code;
  endtask

  task automatic idle_step(input logic rr);
    step(1'b0, 18'($urandom()), 18'($urandom()), 1'($urandom()), rr);
  endtask

  task automatic do_reset();
    u_if.in_valid = 1'b0; u_if.in_last = 1'b0; u_if.res_ready = 1'b0;
    u_if.in_a = '0; u_if.in_b = '0;
    rst = 1'b1;
    #2;
    chk("rst_in_ready", 64'(u_if.in_ready), 64'd1);
    chk("rst_res_valid", 64'(u_if.res_valid), 64'd0);
    chk("rst_res_data", 64'(u_if.res_data), 64'd0);
    chk("rst_res_ovf", 64'(u_if.res_ovf), 64'd0);
    chk("rst_dsp_a", 64'(dsp_a), 64'd0);
    chk("rst_dsp_b", 64'(dsp_b), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'd0);
    busy = 1'b0; res_vis = 1'b0; in_dot = 1'b0; cnt = 0; prev_code = 8'h08;
    @(negedge clk);
    rst = 1'b0;
    idle_step(1'b0);
  endtask

  // Wait (bounded) for the result, optionally stall the consumer, then take it.
  task automatic finish_dot(input int hold, input logic vhold);
    int g = 0;
    while (!u_if.res_valid && g < 8) begin
      idle_step(1'b0);
      g++;
    end
    chk("res_latency", 64'(u_if.res_valid), 64'd1);
    for (int i = 0; i < hold; i++)
      step(vhold, 18'($urandom()), 18'($urandom()), 1'($urandom()), 1'b0);
    idle_step(1'b1);
  endtask

  initial begin
    int len, gap;
    do_reset();

    // Single beat.
    step(1'b1, 18'd3, 18'd5, 1'b1, 1'b0);
    finish_dot(0, 1'b0);

    // Four back-to-back beats.
    for (int i = 0; i < 4; i++)
      step(1'b1, 18'(2*i+1), 18'(2*i+2), 1'(i == 3), 1'b0);
    finish_dot(0, 1'b0);

    // Same beats with two bubble cycles between each.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 18'(2*i+1), 18'(2*i+2), 1'(i == 3), 1'b0);
      if (i != 3) begin idle_step(1'b0); idle_step(1'b0); end
    end
    finish_dot(0, 1'b0);

    // Consumer stalls 10 cycles with the source still offering beats.
    for (int i = 0; i < 4; i++)
      step(1'b1, 18'(2*i+1), 18'(2*i+2), 1'(i == 3), 1'b0);
    finish_dot(10, 1'b1);

    // Reset in the middle of a dot product, then a fresh one.
    step(1'b1, 18'd1, 18'd2, 1'b0, 1'b0);
    step(1'b1, 18'd3, 18'd4, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 18'd2, 18'd2, 1'b1, 1'b0);
    finish_dot(0, 1'b0);

    // Randomized dot products with random gaps and consumer stalls.
    for (int d = 0; d < 25; d++) begin
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        step(1'b1, 18'($urandom()), 18'($urandom()), 1'(i == len - 1), 1'b0);
        gap = int'($urandom_range(0, 2));
        if (i != len - 1)
          for (int k = 0; k < gap; k++) idle_step(1'b0);
      end
      finish_dot(int'($urandom_range(0, 3)), 1'($urandom()));
    end

    // Long full-scale accumulation wraps past 2^48.
    for (int i = 0; i < 4097; i++)
      step(1'b1, MAXV, MAXV, 1'(i == 4096), 1'b0);
    finish_dot(0, 1'b0);

    // Short full-scale run afterwards: overflow flag must restart clear.
    for (int i = 0; i < 8; i++)
      step(1'b1, MAXV, MAXV, 1'(i == 7), 1'b0);
    finish_dot(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
